// File: rtl/md5_padder.sv
// MD5 message padder: packs a byte stream into 512-bit blocks, appends the 0x80 marker and the
// 64-bit little-endian bit length, and sequences md5_core start pulses block by block.
module md5_padder #(
    parameter int unsigned LEN_W = 32
) (
    input  logic         clk,
    input  logic         h_rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    input  logic         core_done,
    output logic [0:511] block_data,
    output logic         core_hrst,
    output logic         core_srst,
    output logic         msg_done
);

    typedef enum logic [1:0] {StFill, StPad, StIssue, StWait} state_e;

    state_e           state_q, state_d;
    logic [0:511]     blk_q, blk_d;
    logic [5:0]       idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             extra_q, extra_d;
    logic             rdy_q, rdy_d;
    logic             done_q;

    logic             accept;
    logic             done_rise;
    logic             put_len;
    logic [5:0]       p;
    logic [63:0]      bit_len;

    assign accept     = in_valid && rdy_q && (state_q == StFill);
    // A done level carried over from the previous block has done_q already high.
    assign done_rise  = core_done && !done_q;
    assign p          = len_q[5:0];
    assign bit_len    = 64'(len_q) << 3;
    assign in_ready   = rdy_q;
    assign block_data = blk_q;

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        idx_d     = idx_q;
        len_d     = len_q;
        first_d   = first_q;
        last_d    = last_q;
        extra_d   = extra_q;
        put_len   = 1'b0;
        core_hrst = 1'b0;
        core_srst = 1'b0;
        msg_done  = 1'b0;

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    blk_d[{idx_q, 3'b000} +: 8] = in_data;
                    idx_d = idx_q + 6'd1;
                    len_d = len_q + LEN_W'(1);
                    if (in_last) begin
                        last_d = 1'b1;
                        // Last byte fills the block: marker and length go in an extra block.
                        if (idx_q == 6'd63) begin
                            extra_d = 1'b1;
                            state_d = StIssue;
                        end else begin
                            state_d = StPad;
                        end
                    end else if (idx_q == 6'd63) begin
                        state_d = StIssue;
                    end
                end
            end
            StPad: begin
                state_d = StIssue;
                if (extra_q) begin
                    blk_d = '0;
                    if (p == 6'd0) begin
                        blk_d[0 +: 8] = 8'h80;
                    end
                    put_len = 1'b1;
                    extra_d = 1'b0;
                end else begin
                    blk_d[{p, 3'b000} +: 8] = 8'h80;
                    if (p < 6'd56) begin
                        put_len = 1'b1;
                    end else begin
                        extra_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                core_hrst = first_q;
                core_srst = !first_q;
                first_d   = 1'b0;
                state_d   = StWait;
            end
            StWait: begin
                if (done_rise) begin
                    if (extra_q) begin
                        state_d = StPad;
                    end else begin
                        blk_d   = '0;
                        idx_d   = 6'd0;
                        state_d = StFill;
                        if (last_q) begin
                            msg_done = 1'b1;
                            first_d  = 1'b1;
                            last_d   = 1'b0;
                            len_d    = '0;
                        end
                    end
                end
            end
            default: state_d = StFill;
        endcase

        if (put_len) begin
            for (int i = 0; i < 8; i++) begin
                blk_d[(56 + i) * 8 +: 8] = bit_len[i * 8 +: 8];
            end
        end

        rdy_d = (state_d == StFill);
    end

    always_ff @(posedge clk or posedge h_rst) begin
        if (h_rst) begin
            state_q <= StFill;
            blk_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            extra_q <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            first_q <= first_d;
            last_q  <= last_d;
            extra_q <= extra_d;
            rdy_q   <= rdy_d;
            done_q  <= core_done;
        end
    end

endmodule

// File: tb/tb_md5_padder.sv
// Directed bench for md5_padder: a padding model fills a scoreboard of expected blocks, which a
// monitor pops on every core start pulse.
module tb_md5_padder;

    logic         clk;
    logic         h_rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         core_done;
    logic [0:511] block_data;
    logic         core_hrst;
    logic         core_srst;
    logic         msg_done;

    typedef struct packed {
        logic [0:511] blk;
        logic         hrst;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    bit   auto_done = 1'b1;

    md5_padder #(.LEN_W(32)) dut (
        .clk        (clk),
        .h_rst      (h_rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .core_done  (core_done),
        .block_data (block_data),
        .core_hrst  (core_hrst),
        .core_srst  (core_srst),
        .msg_done   (msg_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference MD5 padding, split into expected blocks.
    task automatic push_msg(input logic [7:0] msg[$]);
        logic [7:0]   pad[$];
        logic [63:0]  bits;
        logic [0:511] b;
        exp_t         e;
        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 0; i < 8; i++) pad.push_back(bits[i * 8 +: 8]);
        for (int n = 0; n < pad.size() / 64; n++) begin
            for (int k = 0; k < 64; k++) b[k * 8 +: 8] = pad[n * 64 + k];
            e.blk  = b;
            e.hrst = (n == 0);
            sb.push_back(e);
        end
    endtask

    // Called at posedge+2; returns at posedge+2 right after the byte is accepted.
    task automatic send_byte(input logic [7:0] d, input bit last);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) chk("accept_timeout", 512'(in_ready), 512'(1'b1));
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit exp_h);
        @(posedge clk);
        #2;
        for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1);
        @(negedge clk);
        chk("pad_quiet", 512'({core_hrst, core_srst}), 512'(2'b00));
        @(negedge clk);
        chk("issue_latency", 512'({core_hrst, core_srst}), 512'(exp_h ? 2'b10 : 2'b01));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || done_cnt != exp_done) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("sb_drained", 512'(sb.size()), 512'(0));
        chk("msg_done_count", 512'(done_cnt), 512'(exp_done));
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!h_rst) begin
            if (core_hrst || core_srst) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_block: got %h want none", block_data);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("block", 512'(block_data), 512'(e.blk));
                    chk("start_kind", 512'({core_hrst, core_srst}),
                        512'(e.hrst ? 2'b10 : 2'b01));
                end
            end
            if (msg_done) done_cnt++;
        end
    end

    // Core model: drop done after a start pulse, raise it two cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_done && (core_hrst || core_srst)) begin
                @(posedge clk);
                #2 core_done = 1'b0;
                repeat (2) @(posedge clk);
                #2 core_done = 1'b1;
            end
        end
    end

    initial begin
        logic [7:0] m[$];
        h_rst     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        core_done = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 512'(in_ready), 512'(0));
        chk("rst_block", 512'(block_data), 512'(0));
        chk("rst_pulses", 512'({core_hrst, core_srst, msg_done}), 512'(0));
        h_rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rel0", 512'(in_ready), 512'(0));
        @(negedge clk);
        chk("ready_after_rel1", 512'(in_ready), 512'(1));

        // "abc"
        m = {8'h61, 8'h62, 8'h63};
        push_msg(m);
        exp_done++;
        send_msg(m, 1'b1);
        wait_idle();

        // 100 x 0x58: data block then padded srst block
        m = {};
        for (int i = 0; i < 100; i++) m.push_back(8'h58);
        push_msg(m);
        exp_done++;
        send_msg(m, 1'b0);
        wait_idle();

        // 56 zeros: marker ends block 1, length in block 2
        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'h00);
        push_msg(m);
        exp_done++;
        send_msg(m, 1'b1);
        wait_idle();

        // 55 bytes: largest single-block message
        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'(i * 3 + 1));
        push_msg(m);
        exp_done++;
        send_msg(m, 1'b1);
        wait_idle();

        // 64 bytes: last byte fills block, marker owed in extra block
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(i));
        push_msg(m);
        exp_done++;
        @(posedge clk);
        #2;
        for (int i = 0; i < 64; i++) send_byte(m[i], i == 63);
        wait_idle();

        // core_done held high into WAIT, and bytes offered during WAIT
        auto_done = 1'b0;
        @(posedge clk);
        #2 core_done = 1'b1;
        m = {8'h78, 8'h79, 8'h7a};
        push_msg(m);
        exp_done++;
        send_msg(m, 1'b1);
        @(posedge clk);
        #2;
        in_data  = 8'hee;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("wait_ready_low", 512'(in_ready), 512'(0));
            chk("wait_no_done", 512'(msg_done), 512'(0));
        end
        @(posedge clk);
        #2 core_done = 1'b0;
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        chk("done_on_rise", 512'(msg_done), 512'(1));
        wait_idle();

        // Reset during WAIT of block 1
        core_done = 1'b0;
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(8'hA0 + i));
        push_msg(m);
        void'(sb.pop_back());
        @(posedge clk);
        #2;
        for (int i = 0; i < 64; i++) send_byte(m[i], 1'b0);
        repeat (3) @(posedge clk);
        #2 h_rst = 1'b1;
        #1;
        chk("midrst_ready", 512'(in_ready), 512'(0));
        chk("midrst_block", 512'(block_data), 512'(0));
        chk("midrst_pulses", 512'({core_hrst, core_srst, msg_done}), 512'(0));
        chk("midrst_sb", 512'(sb.size()), 512'(0));
        @(posedge clk);
        #2 h_rst = 1'b0;
        auto_done = 1'b1;

        // Fresh message after reset: hrst and correct length
        m = {8'h61, 8'h62, 8'h63};
        push_msg(m);
        exp_done++;
        send_msg(m, 1'b1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
